// File: rtl/wb_unit.sv
// -----------------------------------------------------------------------------
// wb_unit -- registered write-back stage
//
// Sits after the MEM stage and drives the register-file write port. For loads
// it picks the addressed byte or halfword out of the memory read data and
// extends it, or merges the read data with rt. A ready/valid handshake lets a
// load wait in WAIT_MEM until a multi-cycle data memory answers.
//
// Parameters
//   DATA_W      datapath width, 32 or 64
//   REG_ADDR_W  register-file address width
//   OFF_W       byte-offset width, derived from DATA_W (not overridable)
//
// Ports
//   clk          clock, rising edge
//   nrst         asynchronous active-low reset
//   in_valid     MEM stage presents an instruction
//   in_ready     stage can accept an instruction (depends on state only)
//   mem_to_reg   1 = result from memory, 0 = result is alu_data
//   mem_func     load function: BS BU HS HU WD WL WR WC (0..7)
//   byte_off     byte address offset of the load
//   alu_data     ALU result
//   rt_data      rt operand, used by WL/WR merge and WC compare
//   dest         destination register
//   reg_we       instruction writes a register
//   rdata        data memory read data
//   rdata_valid  rdata is valid this cycle
//   wb_valid     registered result valid
//   wb_we        register-file write enable (suppressed for r0)
//   wb_addr      register-file write address
//   wb_data      register-file write data
//   stall_cycles saturating count of cycles spent in WAIT_MEM
//                (present only when WB_STALLCNT_EN is defined)
//
// Build option
//   WB_STALLCNT_EN  adds the stall_cycles output and its counter.
// -----------------------------------------------------------------------------
module wb_unit #(
    parameter  int DATA_W     = 32,
    parameter  int REG_ADDR_W = 5,
    localparam int OFF_W      = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_to_reg,
    input  logic [2:0]            mem_func,
    input  logic [OFF_W-1:0]      byte_off,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  reg_we,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  rdata_valid,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data
`ifdef WB_STALLCNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int HALF = DATA_W / 2;

    localparam logic [2:0] F_BS = 3'd0;
    localparam logic [2:0] F_BU = 3'd1;
    localparam logic [2:0] F_HS = 3'd2;
    localparam logic [2:0] F_HU = 3'd3;
    localparam logic [2:0] F_WD = 3'd4;
    localparam logic [2:0] F_WL = 3'd5;
    localparam logic [2:0] F_WR = 3'd6;

    typedef enum logic [0:0] {
        READY    = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    // Load lane extraction / merge. Halfword lanes ignore byte_off[0].
    function automatic logic [DATA_W-1:0] extract(
        input logic [2:0]        func,
        input logic [OFF_W-1:0]  off,
        input logic [DATA_W-1:0] rd,
        input logic [DATA_W-1:0] rt
    );
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [OFF_W-1:0]   hoff;
        logic [DATA_W-1:0]  res;
        hoff   = {off[OFF_W-1:1], 1'b0};
        byte_s = 8'(rd >> {off, 3'b000});
        half_s = 16'(rd >> {hoff, 3'b000});
        case (func)
            F_BS:    res = {{(DATA_W-8){byte_s[7]}}, byte_s};
            F_BU:    res = {{(DATA_W-8){1'b0}}, byte_s};
            F_HS:    res = {{(DATA_W-16){half_s[15]}}, half_s};
            F_HU:    res = {{(DATA_W-16){1'b0}}, half_s};
            F_WD:    res = rd;
            F_WL:    res = {rd[DATA_W-1:HALF], rt[HALF-1:0]};
            F_WR:    res = {rt[DATA_W-1:HALF], rd[HALF-1:0]};
            default: res = {{(DATA_W-1){1'b0}}, (rt == rd)};
        endcase
        return res;
    endfunction

    state_t state, state_nxt;

    logic produce;   // a result is registered at the next edge
    logic park;      // a load is accepted but its data is not here yet
    logic use_cap;   // take load fields from the capture registers

    // Load fields held while waiting for memory
    logic [2:0]            func_p1;
    logic [OFF_W-1:0]      off_p1;
    logic [DATA_W-1:0]     rt_p1;
    logic [REG_ADDR_W-1:0] dest_p1;
    logic                  we_p1;

    logic [2:0]            sel_func;
    logic [OFF_W-1:0]      sel_off;
    logic [DATA_W-1:0]     sel_rt;
    logic [REG_ADDR_W-1:0] sel_dest;
    logic                  sel_we;
    logic                  sel_load;
    logic [DATA_W-1:0]     result;

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= READY;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; in READY every valid instruction is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            READY:    if (in_valid && mem_to_reg && !rdata_valid) state_nxt = WAIT_MEM;
            WAIT_MEM: if (rdata_valid) state_nxt = READY;
            default:  state_nxt = READY;
        endcase
    end

    // FSM outputs; in_ready depends on state alone
    always_comb begin
        in_ready = 1'b0;
        produce  = 1'b0;
        park     = 1'b0;
        use_cap  = 1'b0;
        case (state)
            READY: begin
                in_ready = 1'b1;
                produce  = in_valid && (!mem_to_reg || rdata_valid);
                park     = in_valid && mem_to_reg && !rdata_valid;
            end
            WAIT_MEM: begin
                produce = rdata_valid;
                use_cap = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture stage: hold the parked load's fields (data only, no reset)
    always_ff @(posedge clk) begin
        if (park) begin
            func_p1 <= mem_func;
            off_p1  <= byte_off;
            rt_p1   <= rt_data;
            dest_p1 <= dest;
            we_p1   <= reg_we;
        end
    end

    always_comb begin
        sel_func = use_cap ? func_p1 : mem_func;
        sel_off  = use_cap ? off_p1  : byte_off;
        sel_rt   = use_cap ? rt_p1   : rt_data;
        sel_dest = use_cap ? dest_p1 : dest;
        sel_we   = use_cap ? we_p1   : reg_we;
        sel_load = use_cap || mem_to_reg;
        result   = sel_load ? extract(sel_func, sel_off, rdata, sel_rt) : alu_data;
    end

    // Write-port stage: address and data hold when nothing is produced
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= produce;
            wb_we    <= produce && sel_we && (sel_dest != '0);
            if (produce) begin
                wb_addr <= sel_dest;
                wb_data <= result;
            end
        end
    end

`ifdef WB_STALLCNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cycles <= '0;
        end else if (state == WAIT_MEM) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;

    // 32-bit instance
    logic        in_valid, in_ready, mem_to_reg, reg_we, rdata_valid;
    logic [2:0]  mem_func;
    logic [1:0]  byte_off;
    logic [31:0] alu_data, rt_data, rdata, wb_data;
    logic [4:0]  dest, wb_addr;
    logic        wb_valid, wb_we;
`ifdef WB_STALLCNT_EN
    logic [31:0] stall_cycles;
`endif

    // 64-bit instance
    logic        in_valid_w, in_ready_w, mem_to_reg_w, reg_we_w, rdata_valid_w;
    logic [2:0]  mem_func_w;
    logic [2:0]  byte_off_w;
    logic [63:0] alu_data_w, rt_data_w, rdata_w, wb_data_w;
    logic [4:0]  dest_w, wb_addr_w;
    logic        wb_valid_w, wb_we_w;
`ifdef WB_STALLCNT_EN
    logic [31:0] stall_cycles_w;
`endif

    wb_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_to_reg(mem_to_reg), .mem_func(mem_func), .byte_off(byte_off),
        .alu_data(alu_data), .rt_data(rt_data), .dest(dest), .reg_we(reg_we),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef WB_STALLCNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    wb_unit #(.DATA_W(64), .REG_ADDR_W(5)) dut64 (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .mem_to_reg(mem_to_reg_w), .mem_func(mem_func_w), .byte_off(byte_off_w),
        .alu_data(alu_data_w), .rt_data(rt_data_w), .dest(dest_w), .reg_we(reg_we_w),
        .rdata(rdata_w), .rdata_valid(rdata_valid_w),
        .wb_valid(wb_valid_w), .wb_we(wb_we_w), .wb_addr(wb_addr_w), .wb_data(wb_data_w)
`ifdef WB_STALLCNT_EN
        , .stall_cycles(stall_cycles_w)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        m2r;
        logic [2:0]  func;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] rd;
        logic        e_we;
        logic [31:0] e_data;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic m2r, input logic [2:0] func, input logic [1:0] off,
                                input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] d,
                                input logic we, input logic [31:0] rd, input logic e_we,
                                input logic [31:0] e_data);
        vec_t v;
        v.m2r = m2r; v.func = func; v.off = off; v.alu = alu; v.rt = rt;
        v.dest = d; v.we = we; v.rd = rd; v.e_we = e_we; v.e_data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        in_valid = 1'b0; mem_to_reg = 1'b0; mem_func = 3'd0; byte_off = 2'd0;
        alu_data = '0; rt_data = '0; dest = '0; reg_we = 1'b0;
        rdata = '0; rdata_valid = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        idle32();
        in_valid_w = 1'b0; mem_to_reg_w = 1'b0; mem_func_w = 3'd0; byte_off_w = 3'd0;
        alu_data_w = '0; rt_data_w = '0; dest_w = '0; reg_we_w = 1'b0;
        rdata_w = '0; rdata_valid_w = 1'b0;

        vecs[0]  = mk(0, 3'd0, 2'd0, 32'h12345678, 32'h0,        5'd3,  1, 32'h0,        1, 32'h12345678);
        vecs[1]  = mk(1, 3'd0, 2'd2, 32'h0,        32'h0,        5'd5,  1, 32'h0080FF00, 1, 32'hFFFFFF80);
        vecs[2]  = mk(1, 3'd1, 2'd2, 32'h0,        32'h0,        5'd5,  1, 32'h0080FF00, 1, 32'h00000080);
        vecs[3]  = mk(1, 3'd2, 2'd0, 32'h0,        32'h0,        5'd7,  1, 32'h12348001, 1, 32'hFFFF8001);
        vecs[4]  = mk(1, 3'd3, 2'd3, 32'h0,        32'h0,        5'd8,  1, 32'hBEEF0001, 1, 32'h0000BEEF);
        vecs[5]  = mk(1, 3'd4, 2'd1, 32'h0,        32'h0,        5'd10, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
        vecs[6]  = mk(1, 3'd5, 2'd0, 32'h0,        32'hAAAABBBB, 5'd11, 1, 32'h11112222, 1, 32'h1111BBBB);
        vecs[7]  = mk(1, 3'd6, 2'd0, 32'h0,        32'hAAAABBBB, 5'd11, 1, 32'h11112222, 1, 32'hAAAA2222);
        vecs[8]  = mk(1, 3'd7, 2'd0, 32'h0,        32'h55AA55AA, 5'd13, 1, 32'h55AA55AA, 1, 32'h00000001);
        vecs[9]  = mk(1, 3'd7, 2'd0, 32'h0,        32'h55AA55AA, 5'd13, 1, 32'h55AA55AB, 1, 32'h00000000);
        vecs[10] = mk(0, 3'd0, 2'd0, 32'h0000DEAD, 32'h0,        5'd0,  1, 32'h0,        0, 32'h0000DEAD);
        vecs[11] = mk(0, 3'd0, 2'd0, 32'h00000001, 32'h0,        5'd9,  0, 32'h0,        0, 32'h00000001);
        vecs[12] = mk(1, 3'd0, 2'd3, 32'h0,        32'h0,        5'd14, 1, 32'h7F000000, 1, 32'h0000007F);
        vecs[13] = mk(1, 3'd1, 2'd0, 32'h0,        32'h0,        5'd12, 1, 32'h000000FF, 1, 32'h000000FF);

        // Reset state
        #12;
        check("rst in_ready", in_ready, 1);
        check("rst wb_valid", wb_valid, 0);
        check("rst wb_we",    wb_we,    0);
        check("rst wb_addr",  wb_addr,  0);
        check("rst wb_data",  wb_data,  0);
`ifdef WB_STALLCNT_EN
        check("rst stall_cycles", stall_cycles, 0);
`endif
        nrst = 1'b1;

        // Back-to-back single-cycle instructions
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; mem_to_reg = vecs[i].m2r; mem_func = vecs[i].func;
            byte_off = vecs[i].off; alu_data = vecs[i].alu; rt_data = vecs[i].rt;
            dest = vecs[i].dest; reg_we = vecs[i].we; rdata = vecs[i].rd; rdata_valid = 1'b1;
            tick();
            check($sformatf("v%0d wb_valid", i), wb_valid, 1);
            check($sformatf("v%0d wb_we", i),    wb_we,    vecs[i].e_we);
            check($sformatf("v%0d wb_addr", i),  wb_addr,  vecs[i].dest);
            check($sformatf("v%0d wb_data", i),  wb_data,  vecs[i].e_data);
            check($sformatf("v%0d in_ready", i), in_ready, 1);
        end

        // Idle with stray rdata_valid: no result, address/data hold
        idle32();
        rdata_valid = 1'b1; rdata = 32'hFFFFFFFF;
        tick();
        check("idle wb_valid", wb_valid, 0);
        check("idle wb_we",    wb_we,    0);
        check("idle wb_addr hold", wb_addr, vecs[NV-1].dest);
        check("idle wb_data hold", wb_data, vecs[NV-1].e_data);
        check("idle in_ready", in_ready, 1);

        // Waiting load HU, byte_off=2, data 3 cycles after accept
        idle32();
        in_valid = 1'b1; mem_to_reg = 1'b1; mem_func = 3'd3; byte_off = 2'd2;
        dest = 5'd4; reg_we = 1'b1; rt_data = 32'h0;
        tick();
        check("wait c1 in_ready", in_ready, 0);
        check("wait c1 wb_valid", wb_valid, 0);
        // Scrambled fields prove the captured ones are used
        in_valid = 1'b0; mem_func = 3'd4; byte_off = 2'd0; dest = 5'd0; reg_we = 1'b0;
        tick();
        check("wait c2 in_ready", in_ready, 0);
        check("wait c2 wb_valid", wb_valid, 0);
        // A valid non-load presented while stalled must not be taken
        in_valid = 1'b1; mem_to_reg = 1'b0; alu_data = 32'h99999999; dest = 5'd20;
        tick();
        check("wait c3 in_ready", in_ready, 0);
        check("wait c3 wb_valid", wb_valid, 0);
        in_valid = 1'b0; rdata = 32'hBEEF0001; rdata_valid = 1'b1;
        tick();
        check("wait done wb_valid", wb_valid, 1);
        check("wait done wb_we",    wb_we,    1);
        check("wait done wb_addr",  wb_addr,  4);
        check("wait done wb_data",  wb_data,  32'h0000BEEF);
        check("wait done in_ready", in_ready, 1);
`ifdef WB_STALLCNT_EN
        check("wait stall_cycles", stall_cycles, 3);
`endif
        idle32();
        tick();
        check("wait after wb_valid", wb_valid, 0);

        // Reset while in WAIT_MEM
        in_valid = 1'b1; mem_to_reg = 1'b1; mem_func = 3'd4; dest = 5'd6; reg_we = 1'b1;
        tick();
        check("rstw in_ready before", in_ready, 0);
        idle32();
        #2;
        nrst = 1'b0;
        #1;
        check("rstw in_ready", in_ready, 1);
        check("rstw wb_valid", wb_valid, 0);
        check("rstw wb_we",    wb_we,    0);
        check("rstw wb_addr",  wb_addr,  0);
        check("rstw wb_data",  wb_data,  0);
`ifdef WB_STALLCNT_EN
        check("rstw stall_cycles", stall_cycles, 0);
`endif
        tick();
        nrst = 1'b1;
        rdata = 32'h12345678; rdata_valid = 1'b1;
        tick();
        check("rstw late wb_valid", wb_valid, 0);
        check("rstw late wb_we",    wb_we,    0);
        check("rstw late in_ready", in_ready, 1);
        idle32();

        // DATA_W = 64
        in_valid_w = 1'b1; mem_to_reg_w = 1'b1; mem_func_w = 3'd4; byte_off_w = 3'd0;
        dest_w = 5'd2; reg_we_w = 1'b1; rdata_w = 64'h0123456789ABCDEF; rdata_valid_w = 1'b1;
        tick();
        check("w64 WD wb_valid", wb_valid_w, 1);
        check("w64 WD wb_we",    wb_we_w,    1);
        check("w64 WD wb_addr",  wb_addr_w,  2);
        check("w64 WD wb_data",  wb_data_w,  64'h0123456789ABCDEF);
        mem_func_w = 3'd0; byte_off_w = 3'd7; rdata_w = 64'h80FF000000000000;
        tick();
        check("w64 BS wb_data",  wb_data_w,  64'hFFFFFFFFFFFFFF80);
        mem_func_w = 3'd5; byte_off_w = 3'd0;
        rt_data_w = 64'hAAAAAAAABBBBBBBB; rdata_w = 64'h1111111122222222;
        tick();
        check("w64 WL wb_data",  wb_data_w,  64'h11111111BBBBBBBB);
        in_valid_w = 1'b0; rdata_valid_w = 1'b0;
        tick();
        check("w64 idle wb_valid", wb_valid_w, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
